mem_access_requester: RTL and testbench

- Initiator side of the core's memory access protocol (order/io/address/data, answered by accepted/accessed/o_data).
- Sits between the execute stage and the memory block.
- Takes one load or store request at a time, drives the protocol, waits for completion, and returns load data plus destination register to writeback.
- Adds a watchdog so a stalled memory cannot hang the core silently.

---
 rtl/mem_access_requester_pkg.sv | 27 ++
 rtl/mem_access_requester_if.sv | 25 ++
 rtl/mem_access_requester_access_watchdog.sv | 41 ++++
 rtl/mem_access_requester.sv | 153 +++++++++++++++
 tb/tb_mem_access_requester.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_requester_pkg.sv
// Shared widths, state encoding and helpers for the
// memory access requester and its watchdog.
package mem_access_requester_pkg;

  localparam int LEN_MEM_ADDR = 16;
  localparam int LEN_WORD     = 32;
  localparam int LEN_REG_ADDR = 5;

  localparam logic IO_LOAD  = 1'b0;
  localparam logic IO_STORE = 1'b1;

  typedef enum logic [1:0] {
    MAR_IDLE  = 2'd0,
    MAR_ISSUE = 2'd1,
    MAR_WAIT  = 2'd2,
    MAR_DONE  = 2'd3
  } mar_state_e;

  // Loads return memory data; stores complete with zero.
  function automatic logic [LEN_WORD-1:0] capture_data(
    input logic                io,
    input logic [LEN_WORD-1:0] rdata
  );
    return (io == IO_STORE) ? '0 : rdata;
  endfunction

endpackage

// File: rtl/mem_access_requester_if.sv
// Memory-side protocol bundle: order/io/address/data out,
// accepted/accessed/read data back.
interface mem_access_requester_if
  import mem_access_requester_pkg::*;
  ();

  logic                    order;
  logic                    io;
  logic [LEN_MEM_ADDR-1:0] address;
  logic [LEN_WORD-1:0]     o_wdata;
  logic                    accepted;
  logic                    accessed;
  logic [LEN_WORD-1:0]     i_rdata;

  modport master (
    output order, io, address, o_wdata,
    input  accepted, accessed, i_rdata
  );

  modport slave (
    input  order, io, address, o_wdata,
    output accepted, accessed, i_rdata
  );

endinterface

// File: rtl/mem_access_requester_access_watchdog.sv
// Saturating cycle counter that flags expiry after
// TIMEOUT_CYCLES-1 enabled cycles since the last clear.
module access_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins; otherwise count up and hold at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_access_requester.sv
// Initiator for the memory access protocol: one load/store
// at a time, watchdog-guarded, result handed to writeback.
module mem_access_requester
  import mem_access_requester_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_store_i,
  input  logic [LEN_MEM_ADDR-1:0] req_addr_i,
  input  logic [LEN_WORD-1:0]     req_data_i,
  input  logic [LEN_REG_ADDR-1:0] req_rd_i,
  mem_access_requester_if.master  mem,
  output logic                    done_valid_o,
  input  logic                    done_ready_i,
  output logic                    done_store_o,
  output logic [LEN_REG_ADDR-1:0] done_rd_o,
  output logic [LEN_WORD-1:0]     done_data_o,
  output logic                    done_err_o,
  output logic                    err_sticky_o
);

  mar_state_e              state_q;
  logic                    order_q;
  logic                    io_q;
  logic [LEN_MEM_ADDR-1:0] addr_q;
  logic [LEN_WORD-1:0]     wdata_q;
  logic                    dvalid_q;
  logic                    dstore_q;
  logic [LEN_REG_ADDR-1:0] drd_q;
  logic [LEN_WORD-1:0]     ddata_q;
  logic                    derr_q;
  logic                    sticky_q;

  logic take;
  logic busy;
  logic expired;

  assign req_ready_o = (state_q == MAR_IDLE) ||
                       ((state_q == MAR_DONE) && done_ready_i);
  assign take = req_valid_i && req_ready_o;
  assign busy = (state_q == MAR_ISSUE) ||
                (state_q == MAR_WAIT);

  access_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wdog (
    .clk      (clk),
    .rstn     (rstn),
    .clear_i  (take),
    .enable_i (busy),
    .expired_o(expired)
  );

  // Request FSM; every protocol and result output is registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= MAR_IDLE;
      order_q  <= 1'b0;
      io_q     <= IO_LOAD;
      addr_q   <= '0;
      wdata_q  <= '0;
      dvalid_q <= 1'b0;
      dstore_q <= 1'b0;
      drd_q    <= '0;
      ddata_q  <= '0;
      derr_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      unique case (state_q)
        MAR_IDLE: begin
          if (req_valid_i) begin
            io_q    <= req_store_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_data_i;
            drd_q   <= req_rd_i;
            order_q <= 1'b1;
            state_q <= MAR_ISSUE;
          end
        end
        MAR_ISSUE: begin
          if (mem.accepted && mem.accessed) begin
            order_q  <= 1'b0;
            dvalid_q <= 1'b1;
            dstore_q <= io_q;
            ddata_q  <= capture_data(io_q, mem.i_rdata);
            derr_q   <= 1'b0;
            state_q  <= MAR_DONE;
          end else if (expired) begin
            order_q  <= 1'b0;
            dvalid_q <= 1'b1;
            dstore_q <= io_q;
            ddata_q  <= '0;
            derr_q   <= 1'b1;
            sticky_q <= 1'b1;
            state_q  <= MAR_DONE;
          end else if (mem.accepted) begin
            order_q <= 1'b0;
            state_q <= MAR_WAIT;
          end
        end
        MAR_WAIT: begin
          if (mem.accessed) begin
            dvalid_q <= 1'b1;
            dstore_q <= io_q;
            ddata_q  <= capture_data(io_q, mem.i_rdata);
            derr_q   <= 1'b0;
            state_q  <= MAR_DONE;
          end else if (expired) begin
            dvalid_q <= 1'b1;
            dstore_q <= io_q;
            ddata_q  <= '0;
            derr_q   <= 1'b1;
            sticky_q <= 1'b1;
            state_q  <= MAR_DONE;
          end
        end
        MAR_DONE: begin
          if (done_ready_i) begin
            dvalid_q <= 1'b0;
            if (req_valid_i) begin
              io_q    <= req_store_i;
              addr_q  <= req_addr_i;
              wdata_q <= req_data_i;
              drd_q   <= req_rd_i;
              order_q <= 1'b1;
              state_q <= MAR_ISSUE;
            end else begin
              state_q <= MAR_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign mem.order    = order_q;
  assign mem.io       = io_q;
  assign mem.address  = addr_q;
  assign mem.o_wdata  = wdata_q;
  assign done_valid_o = dvalid_q;
  assign done_store_o = dstore_q;
  assign done_rd_o    = drd_q;
  assign done_data_o  = ddata_q;
  assign done_err_o   = derr_q;
  assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_mem_access_requester.sv
// Randomised and directed bench for mem_access_requester
// against a transaction-level timing model.
module tb_mem_access_requester;
  import mem_access_requester_pkg::*;

  localparam int T = 8;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_store;
  logic [LEN_MEM_ADDR-1:0] req_addr;
  logic [LEN_WORD-1:0]     req_data;
  logic [LEN_REG_ADDR-1:0] req_rd;
  logic                    done_valid;
  logic                    done_ready;
  logic                    done_store;
  logic [LEN_REG_ADDR-1:0] done_rd;
  logic [LEN_WORD-1:0]     done_data;
  logic                    done_err;
  logic                    err_sticky;

  mem_access_requester_if bus ();

  mem_access_requester #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_store_i (req_store),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_rd_i    (req_rd),
    .mem         (bus.master),
    .done_valid_o(done_valid),
    .done_ready_i(done_ready),
    .done_store_o(done_store),
    .done_rd_o   (done_rd),
    .done_data_o (done_data),
    .done_err_o  (done_err),
    .err_sticky_o(err_sticky)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit exp_sticky = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mem_quiet();
    bus.accepted = 1'b0;
    bus.accessed = 1'b0;
    bus.i_rdata  = $urandom;
  endtask

  task automatic rand_req();
    req_valid = 1'($urandom);
    req_store = 1'($urandom);
    req_addr  = 16'($urandom);
    req_data  = $urandom;
    req_rd    = 5'($urandom);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_order"}, 32'(bus.order), 0);
    chk({tag, "_io"}, 32'(bus.io), 0);
    chk({tag, "_addr"}, 32'(bus.address), 0);
    chk({tag, "_wdata"}, bus.o_wdata, 0);
    chk({tag, "_dvalid"}, 32'(done_valid), 0);
    chk({tag, "_dstore"}, 32'(done_store), 0);
    chk({tag, "_drd"}, 32'(done_rd), 0);
    chk({tag, "_ddata"}, done_data, 0);
    chk({tag, "_derr"}, 32'(done_err), 0);
    chk({tag, "_sticky"}, 32'(err_sticky), 0);
    chk({tag, "_rready"}, 32'(req_ready), 1);
  endtask

  // One transaction. The memory takes the order on its k-th
  // cycle and completes w cycles later; the request aborts if
  // that lands beyond the watchdog window of T cycles.
  task automatic txn(input bit st,
                     input logic [15:0] ad,
                     input logic [31:0] dt,
                     input logic [4:0] rd,
                     input logic [31:0] rdv,
                     input int k, input int w,
                     input int hold, input bit b2b,
                     output int n_ord,
                     output logic g_err,
                     output logic [31:0] g_data);
    int a;
    int e;
    bit tmo;
    logic [31:0] exp_data;
    a = k - 1 + w;
    tmo = (a > T - 1);
    e = tmo ? T - 1 : a;
    exp_data = (tmo || st) ? 32'd0 : rdv;
    if (b2b) chk("b2b_dvalid", 32'(done_valid), 1);
    req_valid  = 1'b1;
    req_store  = st;
    req_addr   = ad;
    req_data   = dt;
    req_rd     = rd;
    done_ready = b2b;
    mem_quiet();
    #1 chk("req_ready_take", 32'(req_ready), 1);
    @(negedge clk);
    n_ord = 0;
    for (int i = 0; i <= e; i++) begin
      chk("order", 32'(bus.order), 32'(i <= k - 1));
      n_ord += int'(bus.order);
      chk("address", 32'(bus.address), 32'(ad));
      chk("io", 32'(bus.io), 32'(st));
      chk("wdata", bus.o_wdata, dt);
      chk("dvalid_busy", 32'(done_valid), 0);
      rand_req();
      done_ready   = 1'($urandom);
      bus.accepted = (i == k - 1) ||
                     ((i > k - 1) && 1'($urandom));
      bus.accessed = (i == a);
      bus.i_rdata  = (i == a) ? rdv : $urandom;
      #1 chk("req_ready_busy", 32'(req_ready), 0);
      @(negedge clk);
    end
    if (tmo) exp_sticky = 1'b1;
    g_err  = done_err;
    g_data = done_data;
    for (int h = 0; h <= hold; h++) begin
      chk("dvalid", 32'(done_valid), 1);
      chk("dstore", 32'(done_store), 32'(st));
      chk("drd", 32'(done_rd), 32'(rd));
      chk("ddata", done_data, exp_data);
      chk("derr", 32'(done_err), 32'(tmo));
      chk("sticky", 32'(err_sticky), 32'(exp_sticky));
      chk("order_done", 32'(bus.order), 0);
      rand_req();
      done_ready   = 1'b0;
      bus.accepted = 1'($urandom);
      bus.accessed = 1'($urandom);
      bus.i_rdata  = $urandom;
      #1 chk("req_ready_hold", 32'(req_ready), 0);
      @(negedge clk);
    end
  endtask

  task automatic release_done(input int gap);
    chk("rel_dvalid", 32'(done_valid), 1);
    req_valid  = 1'b0;
    done_ready = 1'b1;
    mem_quiet();
    #1 chk("req_ready_rel", 32'(req_ready), 1);
    @(negedge clk);
    for (int g = 0; g < gap; g++) begin
      chk("idle_dvalid", 32'(done_valid), 0);
      chk("idle_order", 32'(bus.order), 0);
      chk("idle_sticky", 32'(err_sticky), 32'(exp_sticky));
      req_valid    = 1'b0;
      done_ready   = 1'($urandom);
      bus.accepted = 1'($urandom);
      bus.accessed = 1'($urandom);
      bus.i_rdata  = $urandom;
      #1 chk("req_ready_idle", 32'(req_ready), 1);
      @(negedge clk);
    end
  endtask

  initial begin
    int          nord;
    logic        gerr;
    logic [31:0] gdata;
    bit          pending;
    bit          b2b;

    rstn       = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    req_rd     = '0;
    done_ready = 1'b0;
    mem_quiet();
    @(negedge clk);
    @(negedge clk);
    check_zero("rst");
    rstn = 1'b1;

    // Single-cycle memory load.
    txn(1'b0, 16'h0010, 32'h0, 5'd5, 32'hDEADBEEF,
        1, 0, 0, 1'b0, nord, gerr, gdata);
    chk("t1_nord", 32'(nord), 1);
    chk("t1_data", gdata, 32'hDEADBEEF);
    chk("t1_err", 32'(gerr), 0);
    release_done(1);

    // Delayed store with 5+ cycles of backpressure.
    txn(1'b1, 16'h0200, 32'h12345678, 5'd3, 32'hFFFF0000,
        4, 4, 5, 1'b0, nord, gerr, gdata);
    chk("t2_nord", 32'(nord), 4);
    chk("t2_data", gdata, 32'h0);
    chk("t2_err", 32'(gerr), 0);

    // Back-to-back load taken in the release cycle.
    txn(1'b0, 16'h0044, 32'h0, 5'd9, 32'h0BADF00D,
        2, 1, 0, 1'b1, nord, gerr, gdata);
    chk("t3_nord", 32'(nord), 2);
    chk("t3_data", gdata, 32'h0BADF00D);
    release_done(3);

    // Memory never accepts: timeout after T order cycles.
    txn(1'b0, 16'h0300, 32'h0, 5'd7, 32'h11111111,
        100, 0, 1, 1'b0, nord, gerr, gdata);
    chk("t4_nord", 32'(nord), T);
    chk("t4_err", 32'(gerr), 1);
    chk("t4_data", gdata, 32'h0);
    release_done(3);
    chk("t4_sticky", 32'(err_sticky), 1);

    // Completion on the expiry cycle wins.
    txn(1'b0, 16'h0404, 32'h0, 5'd1, 32'hCAFE0001,
        1, T - 1, 0, 1'b0, nord, gerr, gdata);
    chk("t5_err", 32'(gerr), 0);
    chk("t5_data", gdata, 32'hCAFE0001);
    chk("t5_sticky", 32'(err_sticky), 1);
    release_done(1);

    // One cycle later is a timeout.
    txn(1'b0, 16'h0408, 32'h0, 5'd2, 32'hCAFE0002,
        1, T, 0, 1'b0, nord, gerr, gdata);
    chk("t6_err", 32'(gerr), 1);
    release_done(1);

    // Reset while waiting for accessed.
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_addr   = 16'h0555;
    req_data   = 32'hA5A5A5A5;
    req_rd     = 5'd4;
    done_ready = 1'b0;
    mem_quiet();
    @(negedge clk);
    req_valid    = 1'b0;
    bus.accepted = 1'b1;
    @(negedge clk);
    mem_quiet();
    rstn = 1'b0;
    @(negedge clk);
    exp_sticky = 1'b0;
    check_zero("rstw");
    rstn         = 1'b1;
    bus.accessed = 1'b1;
    bus.accepted = 1'b1;
    @(negedge clk);
    mem_quiet();
    for (int c = 0; c < 3; c++) begin
      chk("rstw_dvalid", 32'(done_valid), 0);
      chk("rstw_order", 32'(bus.order), 0);
      @(negedge clk);
    end

    // Random traffic.
    pending = 1'b0;
    for (int n = 0; n < 60; n++) begin
      b2b = pending && 1'($urandom);
      if (pending && !b2b) release_done(1 + $urandom % 3);
      txn(1'($urandom), 16'($urandom), $urandom,
          5'($urandom), $urandom,
          1 + $urandom % 5, $urandom % 6,
          $urandom % 3, b2b, nord, gerr, gdata);
      pending = 1'b1;
    end
    release_done(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
